// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS core (add/sub/and/or/nor/slt/jr/lw/sw/beq/j/jal) with
// valid/ready handshakes on instruction and data memories.
module multi_cycle_mips #(
  parameter int unsigned DMEM_AW   = 7,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned NREG_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        IR_addr,
  output logic               IR_req,
  input  logic               IR_valid,
  input  logic [31:0]        IR,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ready,
  output logic [31:0]        RF_writedata,
  output logic               rf_we,
  output logic               retire,
  output logic               illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam int unsigned NREG = 1 << NREG_LOG2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] target_q, target_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] regs_q [NREG];
  logic [31:0] regs_d [NREG];

  logic [5:0]           op, funct;
  logic [NREG_LOG2-1:0] rs_idx, rt_idx, rd_idx, ra_idx, wr_idx;
  logic [31:0]          rs_val, rt_val, sext_imm, pc4, jtarget, alu_r;
  logic                 is_alu, is_jr, is_lw, is_sw, is_beq, is_j, is_jal, legal;

  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs_idx   = NREG_LOG2'(ir_q[25:21]);
  assign rt_idx   = NREG_LOG2'(ir_q[20:16]);
  assign rd_idx   = NREG_LOG2'(ir_q[15:11]);
  assign ra_idx   = NREG_LOG2'(5'd31);
  assign rs_val   = (rs_idx == '0) ? '0 : regs_q[rs_idx];
  assign rt_val   = (rt_idx == '0) ? '0 : regs_q[rt_idx];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc4      = pc_q + 32'd4;
  assign jtarget  = {pc4[31:28], ir_q[25:0], 2'b00};

  assign is_alu = (op == OP_RTYPE) &&
                  (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                   funct == FN_OR  || funct == FN_NOR || funct == FN_SLT);
  assign is_jr  = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_beq = (op == OP_BEQ);
  assign is_j   = (op == OP_J);
  assign is_jal = (op == OP_JAL);
  assign legal  = is_alu | is_jr | is_lw | is_sw | is_beq | is_j | is_jal;

  always_comb begin
    alu_r = '0;
    unique case (funct)
      FN_ADD:  alu_r = a_q + b_q;
      FN_SUB:  alu_r = a_q - b_q;
      FN_AND:  alu_r = a_q & b_q;
      FN_OR:   alu_r = a_q | b_q;
      FN_NOR:  alu_r = ~(a_q | b_q);
      FN_SLT:  alu_r = {31'b0, $signed(a_q) < $signed(b_q)};
      default: alu_r = '0;
    endcase
  end

  // Memory-side outputs come straight from registers, so they stay stable across wait states.
  assign IR_addr    = pc_q;
  assign dmem_we    = is_sw;
  assign dmem_addr  = alu_q[DMEM_AW+1:2];
  assign dmem_wdata = b_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    target_d     = target_q;
    alu_d        = alu_q;
    mdr_d        = mdr_q;
    regs_d       = regs_q;
    IR_req       = 1'b0;
    dmem_req     = 1'b0;
    rf_we        = 1'b0;
    wr_idx       = '0;
    RF_writedata = '0;
    retire       = 1'b0;
    illegal      = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        IR_req = 1'b1;
        if (IR_valid) begin
          ir_d    = IR;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = rs_val;
        b_d      = rt_val;
        target_d = pc4 + (sext_imm << 2);
        state_d  = S_EXEC;
        if (is_j || is_jal) begin
          pc_d    = jtarget;
          retire  = 1'b1;
          state_d = S_FETCH;
          if (is_jal) begin
            rf_we        = 1'b1;
            wr_idx       = ra_idx;
            RF_writedata = pc4;
          end
        end else if (is_jr) begin
          pc_d    = rs_val;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (!legal) begin
          pc_d    = pc4;
          illegal = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          pc_d    = (a_q == b_q) ? target_q : pc4;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          alu_d   = a_q + sext_imm;
          state_d = S_MEM;
        end else begin
          alu_d   = alu_r;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          if (is_sw) begin
            pc_d    = pc4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we        = 1'b1;
        wr_idx       = is_lw ? rt_idx : rd_idx;
        RF_writedata = is_lw ? mdr_q : alu_q;
        pc_d         = pc4;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // R[0] is hard-wired: the strobe is still visible on the ports, the write is dropped.
    if (rf_we && (wr_idx != '0)) regs_d[wr_idx] = RF_writedata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      target_q <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      regs_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      target_q <= target_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Scoreboard bench for multi_cycle_mips: an ISA-level interpreter predicts each
// retirement and data access; a monitor compares what the core presents.
module tb_multi_cycle_mips;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR_addr, IR, dmem_wdata, dmem_rdata, RF_writedata;
  logic        IR_req, IR_valid, dmem_req, dmem_we, dmem_ready, rf_we, retire, illegal;
  logic [6:0]  dmem_addr;

  always #5 clk = ~clk;

  multi_cycle_mips #(.DMEM_AW(7), .RESET_PC(32'h0), .NREG_LOG2(5)) dut (
    .clk(clk), .rst(rst), .IR_addr(IR_addr), .IR_req(IR_req), .IR_valid(IR_valid), .IR(IR),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .RF_writedata(RF_writedata),
    .rf_we(rf_we), .retire(retire), .illegal(illegal)
  );

  typedef struct { logic rf_we; logic [31:0] wdata; logic ill; int unsigned lat; } ret_t;
  typedef struct { logic we; logic [6:0] addr; logic [31:0] wdata; } mem_t;

  ret_t        rq[$];
  mem_t        dq[$];
  logic [31:0] rlog[$];
  logic [31:0] flog[$];
  mem_t        wlog[$];
  int unsigned hlog[$];

  logic [31:0] imem [128];
  logic [31:0] dmem [128];
  logic [31:0] m_mem [128];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  int errors = 0;
  int checks = 0;
  int ir_mode = 0;   // 0 hold, 1 always valid, 2 random
  int dm_mode = 1;   // 0 random, 1 immediate, 2 fixed delay, 3 never ready
  int dm_delay = 0;
  int dm_cnt = 0;
  int n_ret = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_i(input logic [5:0] fn, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] i);
    return (i == 5'd0) ? 32'h0 : m_regs[i];
  endfunction

  // Architectural interpreter: one call per accepted fetch.
  task automatic model_step(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] se, pc4, a, b, ea, nxt;
    ret_t        e;
    mem_t        m;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    se = {{16{ins[15]}}, ins[15:0]};
    pc4 = m_pc + 32'd4;
    a = rr(rs); b = rr(rt);
    nxt = pc4; dest = 5'd0;
    e.rf_we = 1'b0; e.wdata = 32'h0; e.ill = 1'b0; e.lat = 0;
    case (op)
      6'h00: begin
        e.rf_we = 1'b1; e.lat = 4; dest = rd;
        case (fn)
          6'h20: e.wdata = a + b;
          6'h22: e.wdata = a - b;
          6'h24: e.wdata = a & b;
          6'h25: e.wdata = a | b;
          6'h27: e.wdata = ~(a | b);
          6'h2A: e.wdata = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h08: begin e.rf_we = 1'b0; e.lat = 0; nxt = a; end
          default: begin e.rf_we = 1'b0; e.lat = 0; e.ill = 1'b1; end
        endcase
      end
      6'h23: begin
        ea = a + se;
        m.we = 1'b0; m.addr = ea[8:2]; m.wdata = b;
        dq.push_back(m);
        e.rf_we = 1'b1; e.wdata = m_mem[ea[8:2]]; e.lat = 5; dest = rt;
      end
      6'h2B: begin
        ea = a + se;
        m.we = 1'b1; m.addr = ea[8:2]; m.wdata = b;
        dq.push_back(m);
        m_mem[ea[8:2]] = b;
        e.lat = 4;
      end
      6'h04: begin
        nxt = (a == b) ? pc4 + (se << 2) : pc4;
        e.lat = 3;
      end
      6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
      6'h03: begin
        nxt = {pc4[31:28], ins[25:0], 2'b00};
        e.rf_we = 1'b1; e.wdata = pc4; dest = 5'd31;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.rf_we && dest != 5'd0) m_regs[dest] = e.wdata;
    m_pc = nxt;
    rq.push_back(e);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc = 32'h0;
    rq.delete();
    dq.delete();
  endtask

  function automatic logic [31:0] gen_instr();
    int unsigned k;
    logic [4:0]  r1, r2, r3;
    logic [5:0]  fns [6];
    logic [5:0]  bad_ops [4];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    bad_ops = '{6'h01, 6'h08, 6'h0D, 6'h3F};
    k  = $urandom_range(0, 99);
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    r3 = 5'($urandom_range(0, 7));
    if (k < 30) return r_i(fns[$urandom_range(0, 5)], r1, r2, r3);
    if (k < 50) return i_i(6'h23, r2, r1, 16'($urandom_range(0, 511)));
    if (k < 65) return i_i(6'h2B, r2, r1, 16'($urandom_range(0, 511)));
    if (k < 75) return i_i(6'h04, r2, r1, 16'($urandom_range(0, 8)));
    if (k < 81) return {6'h02, 26'($urandom)};
    if (k < 87) return {6'h03, 26'($urandom)};
    if (k < 92) return r_i(6'h08, 5'd0, r2, 5'd0);
    if (k < 96) return {bad_ops[$urandom_range(0, 3)], 26'($urandom)};
    return r_i(6'h00, r1, r2, r3);
  endfunction

  // Instruction SRAM
  initial begin
    logic v;
    IR_valid = 1'b0;
    IR = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      case (ir_mode)
        1:       v = IR_req;
        2:       v = IR_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
        default: v = 1'b0;
      endcase
      IR_valid = v;
      IR = v ? imem[IR_addr[8:2]] : $urandom;
      if (v && IR_req) begin
        check32("fetch_pc", IR_addr, m_pc);
        flog.push_back(IR_addr);
        model_step(imem[IR_addr[8:2]]);
      end
    end
  end

  // Data SRAM
  initial begin
    logic r;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (dmem_req) begin
        case (dm_mode)
          0:       r = ($urandom_range(0, 2) != 0);
          1:       r = 1'b1;
          2:       r = (dm_cnt >= dm_delay);
          default: r = 1'b0;
        endcase
        dm_cnt = r ? 0 : dm_cnt + 1;
      end else begin
        r = (dm_mode == 0) && ($urandom_range(0, 3) == 0);
        dm_cnt = 0;
      end
      dmem_ready = r;
      dmem_rdata = (r && dmem_req) ? dmem[dmem_addr] : $urandom;
      if (r && dmem_req && dmem_we) dmem[dmem_addr] = dmem_wdata;
    end
  end

  // Monitor
  initial begin
    int unsigned cyc, waits, reqcyc;
    ret_t e;
    mem_t w;
    cyc = 0; waits = 0; reqcyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; waits = 0; reqcyc = 0;
      end else begin
        cyc++;
        if ((IR_req && !IR_valid) || (dmem_req && !dmem_ready)) waits++;
        if (dmem_req) begin
          reqcyc++;
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL dmem_unexpected: got addr %h we %b expected no access", dmem_addr, dmem_we);
          end else begin
            check32("dmem_we", {31'b0, dmem_we}, {31'b0, dq[0].we});
            check32("dmem_addr", {25'b0, dmem_addr}, {25'b0, dq[0].addr});
            if (dq[0].we) check32("dmem_wdata", dmem_wdata, dq[0].wdata);
            if (dmem_ready) begin
              if (dmem_we) begin
                w.we = dmem_we; w.addr = dmem_addr; w.wdata = dmem_wdata;
                wlog.push_back(w);
              end
              hlog.push_back(reqcyc);
              reqcyc = 0;
              void'(dq.pop_front());
            end
          end
        end
        if (retire) begin
          rlog.push_back(RF_writedata);
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL retire_unexpected: got retire with data %h expected none", RF_writedata);
          end else begin
            e = rq.pop_front();
            check32("rf_we", {31'b0, rf_we}, {31'b0, e.rf_we});
            check32("rf_wdata", RF_writedata, e.wdata);
            check32("illegal", {31'b0, illegal}, {31'b0, e.ill});
            if (e.lat != 0) check32("latency", cyc - waits, e.lat);
          end
          n_ret++;
          cyc = 0; waits = 0;
        end else begin
          checks++;
          if (rf_we || illegal || RF_writedata != 32'h0) begin
            errors++;
            $display("FAIL idle_strobes: got rf_we %b illegal %b data %h expected 0 0 0",
                     rf_we, illegal, RF_writedata);
          end
        end
      end
    end
  end

  task automatic wait_ret(input int n, input int budget);
    int k;
    k = 0;
    while (n_ret < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_ret < n) begin
      checks++; errors++;
      $display("FAIL retire_timeout: got %0d retirements expected %0d", n_ret, n);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    reset_model();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    for (int i = 0; i < 128; i++) begin
      imem[i] = gen_instr();
      dmem[i] = $urandom;
    end
    dmem[0] = 32'd5; dmem[2] = 32'hFFFF_FFFF; dmem[3] = 32'd1;
    for (int i = 0; i < 128; i++) m_mem[i] = dmem[i];
    imem[0]  = i_i(6'h23, 5'd0, 5'd1, 16'd0);        // lw  $1,0($0)
    imem[1]  = r_i(6'h20, 5'd2, 5'd1, 5'd1);         // add $2,$1,$1
    imem[2]  = i_i(6'h2B, 5'd0, 5'd2, 16'd4);        // sw  $2,4($0)
    imem[3]  = i_i(6'h23, 5'd0, 5'd4, 16'd8);        // lw  $4,8($0)
    imem[4]  = i_i(6'h23, 5'd0, 5'd5, 16'd12);       // lw  $5,12($0)
    imem[5]  = r_i(6'h2A, 5'd3, 5'd4, 5'd5);         // slt $3,$4,$5
    imem[6]  = r_i(6'h20, 5'd0, 5'd1, 5'd1);         // add $0,$1,$1
    imem[7]  = i_i(6'h2B, 5'd0, 5'd0, 16'd16);       // sw  $0,16($0)
    imem[8]  = i_i(6'h2B, 5'd0, 5'd3, 16'd20);       // sw  $3,20($0)
    imem[9]  = {6'h03, 26'h40};                      // jal 0x40
    imem[10] = i_i(6'h04, 5'd1, 5'd1, 16'hFFFF);     // beq $1,$1,-1
    imem[64] = i_i(6'h2B, 5'd0, 5'd31, 16'd24);      // sw  $31,24($0)
    imem[65] = i_i(6'h04, 5'd1, 5'd2, 16'd5);        // beq $1,$2,5 (not taken)
    imem[66] = r_i(6'h27, 5'd6, 5'd1, 5'd2);         // nor $6,$1,$2
    imem[67] = r_i(6'h22, 5'd7, 5'd1, 5'd2);         // sub $7,$1,$2
    imem[68] = r_i(6'h25, 5'd9, 5'd1, 5'd2);         // or  $9,$1,$2
    imem[69] = r_i(6'h08, 5'd0, 5'd31, 5'd0);        // jr  $31
    reset_model();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    reset_model();

    @(negedge clk);
    check32("rst_ir_addr", IR_addr, 32'h0);
    check32("rst_ir_req", {31'b0, IR_req}, 32'd1);
    check32("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check32("rst_retire", {31'b0, retire}, 32'd0);
    check32("rst_rf_wdata", RF_writedata, 32'h0);

    ir_mode = 1; dm_mode = 2; dm_delay = 3;
    wait_ret(18, 600);
    ir_mode = 0;

    if (rlog.size() < 18 || wlog.size() < 4 || flog.size() < 18 || hlog.size() < 2) begin
      checks++; errors++;
      $display("FAIL directed_logs: got %0d retirements expected 18", rlog.size());
    end else begin
      check32("lw_seed", rlog[0], 32'd5);
      check32("add_10", rlog[1], 32'd10);
      check32("slt_signed", rlog[5], 32'd1);
      check32("add_r0_shown", rlog[6], 32'd10);
      check32("jal_link", rlog[9], 32'h28);
      check32("nor", rlog[12], 32'hFFFF_FFF0);
      check32("sub_wrap", rlog[13], 32'hFFFF_FFFB);
      check32("sw_addr", {25'b0, wlog[0].addr}, 32'd1);
      check32("sw_data", wlog[0].wdata, 32'd10);
      check32("sw_hold_cycles", hlog[1], 32'd4);
      check32("r0_reads_0", wlog[1].wdata, 32'h0);
      check32("jal_target", flog[10], 32'h100);
      check32("jr_target", flog[16], 32'h28);
      check32("beq_self", flog[17], 32'h28);
    end

    repeat (6) @(negedge clk);
    pulse_reset();
    dm_mode = 3; ir_mode = 1;
    k = 0;
    while (!dmem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    ir_mode = 0;
    if (!dmem_req) begin
      checks++; errors++;
      $display("FAIL mem_wait_timeout: got dmem_req 0 expected 1");
    end
    k = n_ret;
    pulse_reset();
    @(negedge clk);
    check32("mrst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check32("mrst_ir_addr", IR_addr, 32'h0);
    check32("mrst_ir_req", {31'b0, IR_req}, 32'd1);
    check32("mrst_rf_we", {31'b0, rf_we}, 32'd0);
    check32("mrst_no_retire", n_ret, k);

    for (int i = 0; i < 128; i++) imem[i] = gen_instr();
    ir_mode = 2; dm_mode = 0;
    wait_ret(n_ret + 300, 20000);
    ir_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
